// File: rtl/shift_arbiter.sv
// shift_arbiter: two-requester arbiter over one shared left shifter; SHIFT_ARB_ROUND_ROBIN_EN selects round-robin ties
module shift_arbiter #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_value,
    input  logic [3:0]        req0_shift,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_value,
    input  logic [3:0]        req1_shift,
    output logic              req1_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_value,
    output logic              out_id,
    input  logic              out_ready
);
    typedef enum logic {IDLE, HOLD} state_t;
    state_t state_q, state_d;
    logic [DATA_W-1:0] value_q, value_d, sel_value, shifted;
    logic [3:0] sel_shift, mag;
    logic id_q, id_d, can_grant, g0, g1, xfer;
`ifdef SHIFT_ARB_ROUND_ROBIN_EN
    logic ptr_q, ptr_d;
    always_comb begin
        can_grant = !rst && (state_q == IDLE || out_ready);
        g1 = can_grant && req1_valid && (!req0_valid || ptr_q);
        g0 = can_grant && req0_valid && !g1;
        ptr_d = (g0 || g1) ? g0 : ptr_q;
    end
    always_ff @(posedge clk) ptr_q <= rst ? 1'b0 : ptr_d;
`else
    always_comb begin
        can_grant = !rst && (state_q == IDLE || out_ready);
        g0 = can_grant && req0_valid;
        g1 = can_grant && req1_valid && !req0_valid;
    end
`endif
    always_comb begin
        xfer = g0 || g1;
        sel_value = g1 ? req1_value : req0_value;
        sel_shift = g1 ? req1_shift : req0_shift;
        mag = sel_shift[3] ? -sel_shift : sel_shift;
        shifted = (int'(mag) >= DATA_W) ? '0 : sel_value << mag;
        state_d = xfer ? HOLD : (out_ready ? IDLE : state_q);
        value_d = xfer ? shifted : value_q;
        id_d = xfer ? g1 : id_q;
    end
    always_ff @(posedge clk) begin
        state_q <= rst ? IDLE : state_d;
        value_q <= rst ? '0 : value_d;
        id_q <= rst ? 1'b0 : id_d;
    end
    assign req0_ready = g0;
    assign req1_ready = g1;
    assign out_valid = state_q == HOLD;
    assign out_value = value_q;
    assign out_id = id_q;
endmodule

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 The block SHALL have parameter: DATA_W, 8, width of shifted value.
REQ-002 The block SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 The block SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have ports: req0_valid  input  1; req0_value  input  DATA_W; req0_shift  input  4 (signed); req0_ready  output  1 -- requester 0 (regular-bin renormalisation).
REQ-005 The block SHALL have ports: req1_valid  input  1; req1_value  input  DATA_W; req1_shift  input  4 (signed); req1_ready  output  1 -- requester 1 (bypass-bin path).
REQ-006 The block SHALL have ports: out_valid  output  1; out_value  output  DATA_W; out_id  output  1 (0 = req0, 1 = req1); out_ready  input  1.

Function
REQ-007 The block SHALL contain exactly one shared shifter computing value << |shift|, with |shift| the 4-bit two's-complement magnitude (-8 gives 8).
REQ-008 Shift magnitude >= DATA_W SHALL produce out_value = 0; bits shifted past MSB SHALL be discarded.
REQ-009 The FSM SHALL have states IDLE (output register empty) and HOLD (output register full).
REQ-010 A request SHALL transfer when reqN_valid and reqN_ready are both high on a rising edge.
REQ-011 At most one reqN_ready SHALL be high in any cycle, and only toward a requester with reqN_valid high.
REQ-012 Grant SHALL be possible when state is IDLE, or state is HOLD with out_ready high (same-cycle drain and refill).
REQ-013 Transfer SHALL load out_value, out_id and set out_valid on the next edge: latency one cycle, throughput one result per cycle.
REQ-014 HOLD with out_ready low SHALL keep out_value, out_id, out_valid stable and both reqN_ready low.
REQ-015 HOLD with out_ready high and no granted request SHALL clear out_valid and go to IDLE.
REQ-016 reqN_ready SHALL be combinational from reqN_valid, state, out_ready and priority state; out_* SHALL be registered.
REQ-017 Requester inputs SHALL be sampled only on the transfer edge; changes while not granted SHALL be ignored.

Reset
REQ-018 rst high on a rising edge SHALL force state IDLE, out_valid = 0, out_value = 0, out_id = 0, priority pointer = 0.
REQ-019 While rst is high, req0_ready and req1_ready SHALL be low.
REQ-020 Reset during HOLD SHALL discard the pending result without transfer.

Configuration
REQ-021 With macro SHIFT_ARB_ROUND_ROBIN_EN defined, simultaneous requests SHALL be resolved by a 1-bit pointer favouring the requester not granted most recently; pointer updates only on transfer.
REQ-022 With SHIFT_ARB_ROUND_ROBIN_EN undefined, req0 SHALL always win simultaneous requests and no pointer register SHALL exist.
REQ-023 Single-requester behaviour SHALL be identical in both builds.

Verification
REQ-024 Reset, req0 value 0x13 shift +3, out_ready 1 -> next cycle out_valid 1, out_value 0x98, out_id 0.
REQ-025 req1 value 0x81 shift -1 -> out_value 0x02, out_id 1; req1 shift -8 or +9-equivalent magnitude 8 -> out_value 0x00.
REQ-026 Both valid for 4 cycles, out_ready 1: RR build -> out_id 0,1,0,1; fixed build -> 0,0,0,0.
REQ-027 out_ready low 3 cycles in HOLD -> out_value stable, both reqN_ready low; out_ready high -> new grant same cycle, back-to-back results without bubble.
REQ-028 rst asserted in HOLD with out_ready low -> next cycle out_valid 0, out_value 0, state IDLE, RR pointer 0 (req0 wins next tie).
